reg_memory: RTL and testbench
=============================

Name: reg_memory

Overview:
- Parametrised synchronous word memory, the clocked successor of the 4-word x 3-bit latch memory.
- Configurable word width and depth.
- One write port and one read port, independent addresses; registered read data with a valid strobe.
- Built-in clear sequencer zeroes every word after reset or on request; `busy` is high during the sweep.

Parameters:
WIDTH, 3, bits per word (>=1)
DEPTH, 4, number of words (>=2, power of two not required)
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  WIDTH  write data
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  read address
rd_data  out  WIDTH  registered read data
rd_valid  out  1  one-cycle pulse, rd_data valid
clr  in  1  clear request, sampled one cycle
busy  out  1  clear sweep in progress

Behaviour:
- Reset (rst_n=0, async):
  - FSM enters CLEAR with sweep pointer 0.
  - busy=1, rd_data=0, rd_valid=0.
  - Array contents are not reset directly; the sweep zeroes them.
- FSM states:
  - CLEAR: each cycle write 0 to word[ptr], then ptr++. When ptr==DEPTH-1 is written, go to IDLE next cycle. busy=1 throughout. Exactly DEPTH cycles after reset release, busy falls.
  - IDLE: busy=0; normal operation. clr=1 goes to CLEAR with ptr=0; busy=1 from the next cycle.
- Write: in IDLE, wr_en=1 stores wr_data into word[wr_addr] at the clock edge.
- Read:
  - In IDLE, rd_en=1 gives rd_data=word[rd_addr] and rd_valid=1 on the next cycle (latency 1).
  - When rd_en=0, rd_valid=0 and rd_data holds its last value.
- Read-during-write, same address, same cycle: rd_data returns the new wr_data (write-first bypass).
- Out-of-range address (addr>=DEPTH when DEPTH is not a power of two):
  - Write is ignored.
  - Read returns 0 with rd_valid=1.
- While busy=1:
  - wr_en and rd_en are ignored; rd_valid stays 0.
  - clr is ignored; the sweep does not restart.
- clr and wr_en both high in IDLE: the write completes this edge, then the sweep starts and erases it.
- Reset asserted mid-sweep restarts the sweep from ptr=0.
- Any number of back-to-back reads and writes is legal; there is no other stall.

Decomposition:
- Package reg_memory_pkg holds the FSM state enum (ST_CLEAR, ST_IDLE).
- One sub-module, mem_word (WIDTH flops with write-enable). It is instantiated DEPTH times via generate.
- The top holds the FSM, sweep pointer, write decode, read mux, bypass and output registers.

Test Plan:
1. Reset release, WIDTH=3, DEPTH=4:
   - busy=1 for exactly 4 cycles, then 0.
   - Reads of addr 0..3 all return 0 with rd_valid pulsing.
2. Write 3'b101 to addr 2, read addr 2 the next cycle:
   - rd_data=3'b101 one cycle after rd_en.
   - rd_valid high for exactly 1 cycle.
3. Same cycle: wr_en addr1 data 3'b110, rd_en addr1 -> next cycle rd_data=3'b110 (bypass).
4. Fill words with 1,2,3,4, then pulse clr:
   - busy=1 for 4 cycles.
   - wr_en/rd_en applied during busy have no effect and rd_valid stays 0.
   - Afterwards all words read 0.
5. Drop rst_n for 1 cycle at sweep ptr=2 -> busy stays 1 for a full 4 cycles after release.
6. DEPTH=5, WIDTH=8:
   - Write 8'hA5 to addr 4: reads back 8'hA5.
   - Write to addr 6: ignored.
   - Read addr 6: returns 8'h00 with rd_valid=1.

Source files
------------

// File: rtl/reg_memory_pkg.sv
// Shared types for the reg_memory word store.
package reg_memory_pkg;

  // Controller state: sweeping zeros through the array, or serving reads and writes.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/reg_memory_mem_word.sv
// One storage word: WIDTH flops loaded from d when we is high.
// Ports: clk (rising edge), we (load enable), d (next value), q (stored word).
// The word has no reset; the top-level clear sweep is what zeroes it.
module mem_word #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_memory.sv
// Synchronous word memory with a built-in zero-fill sweep.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wr_en, wr_addr, wr_data     write port
//   rd_en, rd_addr              read request
//   rd_data, rd_valid           registered read result, one-cycle valid pulse
//   clr                         start a clear sweep (taken only when idle)
//   busy                        clear sweep in progress; all requests ignored
module reg_memory
  import reg_memory_pkg::*;
#(
  parameter  int unsigned WIDTH  = 3,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              clr,
  output logic              busy
);

  localparam int unsigned LAST = DEPTH - 1;

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              busy_nxt;
  logic [WIDTH-1:0]  rd_data_nxt;
  logic              rd_valid_nxt;

  logic [DEPTH-1:0]  word_we;
  logic [WIDTH-1:0]  word_d;
  logic [WIDTH-1:0]  word_q [DEPTH];
  logic [WIDTH-1:0]  rd_word;
  logic              rd_in_range;

  // Storage array.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    mem_word #(.WIDTH(WIDTH)) u_word (
      .clk (clk),
      .we  (word_we[g]),
      .d   (word_d),
      .q   (word_q[g])
    );
  end

  // State, sweep pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      ptr      <= '0;
      busy     <= 1'b1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      busy     <= busy_nxt;
      rd_data  <= rd_data_nxt;
      rd_valid <= rd_valid_nxt;
    end
  end

  // Next state, write decode, read mux and bypass.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    busy_nxt     = 1'b0;
    rd_data_nxt  = rd_data;
    rd_valid_nxt = 1'b0;
    word_we      = '0;
    word_d       = '0;
    rd_word      = '0;

    // Addresses at or beyond DEPTH match no word, so they read as zero.
    rd_in_range = (32'(rd_addr) < DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_word = word_q[i];
      end
    end

    case (state)
      ST_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ptr == ADDR_W'(i)) begin
            word_we[i] = 1'b1;
          end
        end
        if (ptr == ADDR_W'(LAST)) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + ADDR_W'(1);
        end
      end

      ST_IDLE: begin
        word_d = wr_data;
        if (wr_en) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
              word_we[i] = 1'b1;
            end
          end
        end
        if (rd_en) begin
          rd_valid_nxt = 1'b1;
          // Write-first: a same-cycle write to the read address is returned directly.
          if (wr_en && (wr_addr == rd_addr) && rd_in_range) begin
            rd_data_nxt = wr_data;
          end else begin
            rd_data_nxt = rd_word;
          end
        end
        // A coincident write still lands this edge; the sweep then erases it.
        if (clr) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end
      end

      default: begin
        state_nxt = ST_CLEAR;
        ptr_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt == ST_CLEAR);
  end

endmodule

// File: tb/tb_reg_memory.sv
// Randomised self-checking bench for reg_memory: a 3x4 instance (A) and an 8x5 instance (B)
// run side by side against an array/counter reference model.
module tb_reg_memory;

  localparam int DA = 4;
  localparam int DB = 5;

  logic       clk;
  logic       rst_n;

  logic       wr_en_a, rd_en_a, clr_a;
  logic [1:0] wr_addr_a, rd_addr_a;
  logic [2:0] wr_data_a;
  logic [2:0] rd_data_a;
  logic       rd_valid_a, busy_a;

  logic       wr_en_b, rd_en_b, clr_b;
  logic [2:0] wr_addr_b, rd_addr_b;
  logic [7:0] wr_data_b;
  logic [7:0] rd_data_b;
  logic       rd_valid_b, busy_b;

  // Reference model state.
  logic [2:0] mem_a [DA];
  logic [7:0] mem_b [DB];
  int         cnt_a, cnt_b;      // sweep cycles still to run
  logic [2:0] exp_d_a;
  logic [7:0] exp_d_b;
  logic       exp_v_a, exp_v_b;

  int n_vec;
  int n_err;

  reg_memory #(.WIDTH(3), .DEPTH(DA)) u_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .clr(clr_a), .busy(busy_a)
  );

  reg_memory #(.WIDTH(8), .DEPTH(DB)) u_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .clr(clr_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    wr_en_a = 0; rd_en_a = 0; clr_a = 0; wr_addr_a = 0; rd_addr_a = 0; wr_data_a = 0;
    wr_en_b = 0; rd_en_b = 0; clr_b = 0; wr_addr_b = 0; rd_addr_b = 0; wr_data_b = 0;
  endtask

  task automatic model_reset();
    cnt_a = DA; cnt_b = DB;
    exp_v_a = 0; exp_v_b = 0;
    exp_d_a = 0; exp_d_b = 0;
  endtask

  // Advance the model by one clock using the current inputs, then step past the edge.
  task automatic tick();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (cnt_a > 0) begin
        mem_a[DA - cnt_a] = 0;
        cnt_a--;
        exp_v_a = 0;
      end else begin
        exp_v_a = rd_en_a;
        if (rd_en_a)
          exp_d_a = (wr_en_a && wr_addr_a == rd_addr_a) ? wr_data_a : mem_a[rd_addr_a];
        if (wr_en_a) mem_a[wr_addr_a] = wr_data_a;
        if (clr_a) cnt_a = DA;
      end
      if (cnt_b > 0) begin
        mem_b[DB - cnt_b] = 0;
        cnt_b--;
        exp_v_b = 0;
      end else begin
        exp_v_b = rd_en_b;
        if (rd_en_b) begin
          if (int'(rd_addr_b) >= DB) exp_d_b = 8'h00;
          else if (wr_en_b && wr_addr_b == rd_addr_b) exp_d_b = wr_data_b;
          else exp_d_b = mem_b[rd_addr_b];
        end
        if (wr_en_b && int'(wr_addr_b) < DB) mem_b[wr_addr_b] = wr_data_b;
        if (clr_b) cnt_b = DB;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int i = 0; i < DA; i++) mem_a[i] = 0;
    for (int i = 0; i < DB; i++) mem_b[i] = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    for (int t = 0; t < 3; t++) begin
      tick();
      n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL rst_busy_a got %b exp 1", busy_a); end
      n_vec++; if (rd_valid_a !== 1'b0) begin n_err++; $display("FAIL rst_valid_a got %b exp 0", rd_valid_a); end
      n_vec++; if (rd_data_a !== 3'd0) begin n_err++; $display("FAIL rst_data_a got %h exp 0", rd_data_a); end
      n_vec++; if (busy_b !== 1'b1) begin n_err++; $display("FAIL rst_busy_b got %b exp 1", busy_b); end
      n_vec++; if (rd_data_b !== 8'd0) begin n_err++; $display("FAIL rst_data_b got %h exp 0", rd_data_b); end
    end
    rst_n = 1'b1;
    // Requests thrown at the sweep must be ignored.
    for (int t = 0; t < DB; t++) begin
      wr_en_a = 1'($urandom); rd_en_a = 1'($urandom); wr_addr_a = 2'($urandom); rd_addr_a = 2'($urandom);
      wr_data_a = 3'($urandom); clr_a = 1'($urandom);
      if (t >= DA - 1) begin wr_en_a = 0; clr_a = 0; rd_en_a = 0; end
      tick();
      n_vec++; if (busy_a !== (cnt_a != 0)) begin n_err++; $display("FAIL sweep_busy_a t=%0d got %b exp %b", t, busy_a, cnt_a != 0); end
      n_vec++; if (busy_b !== (cnt_b != 0)) begin n_err++; $display("FAIL sweep_busy_b t=%0d got %b exp %b", t, busy_b, cnt_b != 0); end
      n_vec++; if (rd_valid_a !== exp_v_a) begin n_err++; $display("FAIL sweep_valid_a t=%0d got %b exp %b", t, rd_valid_a, exp_v_a); end
    end
    idle_inputs();
    for (int i = 0; i < DA; i++) begin
      rd_en_a = 1; rd_addr_a = 2'(i);
      tick();
      n_vec++; if (rd_valid_a !== 1'b1) begin n_err++; $display("FAIL post_rst_valid_a addr=%0d got %b exp 1", i, rd_valid_a); end
      n_vec++; if (rd_data_a !== 3'd0) begin n_err++; $display("FAIL post_rst_data_a addr=%0d got %h exp 0", i, rd_data_a); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    idle_inputs();
    wr_en_a = 1; wr_addr_a = 2; wr_data_a = 3'b101;
    tick();
    idle_inputs();
    rd_en_a = 1; rd_addr_a = 2;
    tick();
    n_vec++; if (rd_data_a !== 3'b101 || rd_data_a !== exp_d_a) begin n_err++; $display("FAIL wr_rd_data got %b exp %b", rd_data_a, exp_d_a); end
    n_vec++; if (rd_valid_a !== 1'b1) begin n_err++; $display("FAIL wr_rd_valid got %b exp 1", rd_valid_a); end
    idle_inputs();
    tick();
    n_vec++; if (rd_valid_a !== 1'b0) begin n_err++; $display("FAIL wr_rd_pulse got %b exp 0", rd_valid_a); end
    n_vec++; if (rd_data_a !== 3'b101) begin n_err++; $display("FAIL wr_rd_hold got %b exp 101", rd_data_a); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    wr_en_a = 1; wr_addr_a = 1; wr_data_a = 3'b110;
    rd_en_a = 1; rd_addr_a = 1;
    tick();
    n_vec++; if (rd_data_a !== 3'b110 || rd_data_a !== exp_d_a) begin n_err++; $display("FAIL bypass_data got %b exp %b", rd_data_a, exp_d_a); end
    n_vec++; if (rd_valid_a !== 1'b1) begin n_err++; $display("FAIL bypass_valid got %b exp 1", rd_valid_a); end
    idle_inputs();
  endtask

  task automatic test_clear();
    idle_inputs();
    for (int i = 0; i < DA; i++) begin
      wr_en_a = 1; wr_addr_a = 2'(i); wr_data_a = 3'(i + 1);
      tick();
    end
    idle_inputs();
    clr_a = 1;
    tick();
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL clr_start_busy got %b exp 1", busy_a); end
    for (int t = 0; t < DA; t++) begin
      wr_en_a = 1; wr_addr_a = 2'($urandom); wr_data_a = 3'($urandom | 1);
      rd_en_a = 1; rd_addr_a = 2'($urandom); clr_a = 1'($urandom);
      if (t == DA - 1) idle_inputs();
      tick();
      n_vec++; if (busy_a !== (t < DA - 1)) begin n_err++; $display("FAIL clr_busy t=%0d got %b exp %b", t, busy_a, t < DA - 1); end
      n_vec++; if (rd_valid_a !== 1'b0) begin n_err++; $display("FAIL clr_valid t=%0d got %b exp 0", t, rd_valid_a); end
    end
    idle_inputs();
    for (int i = 0; i < DA; i++) begin
      rd_en_a = 1; rd_addr_a = 2'(i);
      tick();
      n_vec++; if (rd_data_a !== 3'd0 || rd_valid_a !== 1'b1) begin n_err++; $display("FAIL clr_read addr=%0d got %h/%b exp 0/1", i, rd_data_a, rd_valid_a); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    idle_inputs();
    clr_a = 1;
    tick();
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL midrst_busy got %b exp 1", busy_a); end
    n_vec++; if (rd_valid_a !== 1'b0 || rd_data_a !== 3'd0) begin n_err++; $display("FAIL midrst_out got %h/%b exp 0/0", rd_data_a, rd_valid_a); end
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < DB; t++) begin
      tick();
      n_vec++; if (busy_a !== (t < DA - 1)) begin n_err++; $display("FAIL midrst_sweep_a t=%0d got %b exp %b", t, busy_a, t < DA - 1); end
      n_vec++; if (busy_b !== (cnt_b != 0)) begin n_err++; $display("FAIL midrst_sweep_b t=%0d got %b exp %b", t, busy_b, cnt_b != 0); end
    end
  endtask

  task automatic test_out_of_range();
    idle_inputs();
    for (int g = 0; g < 10 && cnt_b != 0; g++) tick();
    wr_en_b = 1; wr_addr_b = 4; wr_data_b = 8'hA5;
    tick();
    idle_inputs();
    wr_en_b = 1; wr_addr_b = 6; wr_data_b = 8'h3C;
    rd_en_b = 1; rd_addr_b = 4;
    tick();
    n_vec++; if (rd_data_b !== 8'hA5 || rd_data_b !== exp_d_b) begin n_err++; $display("FAIL oor_rd4 got %h exp %h", rd_data_b, exp_d_b); end
    idle_inputs();
    for (int a = 5; a < 8; a++) begin
      rd_en_b = 1; rd_addr_b = 3'(a);
      wr_en_b = 1; wr_addr_b = 3'(a); wr_data_b = 8'($urandom | 1);
      tick();
      n_vec++; if (rd_data_b !== 8'h00 || rd_valid_b !== 1'b1) begin n_err++; $display("FAIL oor_rd%0d got %h/%b exp 00/1", a, rd_data_b, rd_valid_b); end
    end
    idle_inputs();
    for (int a = 0; a < DB; a++) begin
      rd_en_b = 1; rd_addr_b = 3'(a);
      tick();
      n_vec++; if (rd_data_b !== exp_d_b) begin n_err++; $display("FAIL oor_scan%0d got %h exp %h", a, rd_data_b, exp_d_b); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      wr_en_a = 1'($urandom); wr_addr_a = 2'($urandom); wr_data_a = 3'($urandom);
      rd_en_a = 1'($urandom); rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr_a : 2'($urandom);
      clr_a = ($urandom_range(0, 31) == 0);
      wr_en_b = 1'($urandom); wr_addr_b = 3'($urandom); wr_data_b = 8'($urandom);
      rd_en_b = 1'($urandom); rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr_b : 3'($urandom);
      clr_b = ($urandom_range(0, 31) == 0);
      tick();
      n_vec++; if (busy_a !== (cnt_a != 0) || rd_valid_a !== exp_v_a || rd_data_a !== exp_d_a) begin
        n_err++; $display("FAIL rand_a t=%0d got busy=%b v=%b d=%h exp busy=%b v=%b d=%h", t, busy_a, rd_valid_a, rd_data_a, cnt_a != 0, exp_v_a, exp_d_a);
      end
      n_vec++; if (busy_b !== (cnt_b != 0) || rd_valid_b !== exp_v_b || rd_data_b !== exp_d_b) begin
        n_err++; $display("FAIL rand_b t=%0d got busy=%b v=%b d=%h exp busy=%b v=%b d=%h", t, busy_b, rd_valid_b, rd_data_b, cnt_b != 0, exp_v_b, exp_d_b);
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    test_out_of_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
